pe_conv_ctrl: RTL and testbench

Control FSM for one processing element's 1-D row convolution. It sequences the filter scratchpad tap index, the ifmap window base and stride, and the MAC/accumulator enables. It then hands each finished partial sum to the psum writer through a valid/ready handshake. It sits between the PE-array configuration logic and the PE datapath (scratchpads, multiplier, accumulator), replacing free-running counter glue with one scheduler.

---
 rtl/pe_conv_ctrl_pkg.sv | 28 ++
 rtl/pe_conv_ctrl_if.sv | 38 +++
 rtl/pe_conv_ctrl_tap_cnt.sv | 30 +++
 rtl/pe_conv_ctrl.sv | 130 +++++++++++++
 tb/tb_pe_conv_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pe_conv_ctrl_pkg.sv
// Shared types and helpers for the PE row-convolution controller.
// Holds the controller state encoding, default widths and the window-fit test.
package pe_ctrl_pkg;

   localparam int unsigned IF_ADDR_W_DEF = 4;
   localparam int unsigned F_ADDR_W_DEF  = 2;
   localparam int unsigned OUT_W_DEF     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_CLEAR,
      ST_MAC,
      ST_WRITE,
      ST_DONE
   } state_t;

   // True when a window of f taps starting at base ends at or before last.
   // Callers zero-extend; 16 bits leaves headroom so an overflowed base never fits.
   function automatic logic fits(input logic [15:0] base,
                                 input logic [15:0] f,
                                 input logic [15:0] last);
      logic [15:0] w_end;
      w_end = base + f - 16'd1;
      return (w_end <= last);
   endfunction

endpackage

// File: rtl/pe_conv_ctrl_if.sv
// Configuration, handshake and datapath-control bundle between the
// PE-array driver (master) and the convolution controller (slave).
interface pe_conv_ctrl_if
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned IF_ADDR_W = IF_ADDR_W_DEF,
   parameter int unsigned F_ADDR_W  = F_ADDR_W_DEF,
   parameter int unsigned OUT_W     = OUT_W_DEF
);
   logic                 i_start;
   logic [F_ADDR_W:0]    i_filter_size;
   logic [IF_ADDR_W-1:0] i_stride;
   logic [IF_ADDR_W-1:0] i_ifmap_last;
   logic                 i_if_ready;
   logic                 i_psum_ready;

   logic [IF_ADDR_W-1:0] o_ifmap_addr;
   logic [F_ADDR_W-1:0]  o_filter_addr;
   logic                 o_mac_en;
   logic                 o_acc_clr;
   logic                 o_psum_valid;
   logic [OUT_W-1:0]     o_out_idx;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_cfg_err;

   modport master (
      output i_start, i_filter_size, i_stride, i_ifmap_last, i_if_ready, i_psum_ready,
      input  o_ifmap_addr, o_filter_addr, o_mac_en, o_acc_clr, o_psum_valid,
      input  o_out_idx, o_busy, o_done, o_cfg_err
   );

   modport slave (
      input  i_start, i_filter_size, i_stride, i_ifmap_last, i_if_ready, i_psum_ready,
      output o_ifmap_addr, o_filter_addr, o_mac_en, o_acc_clr, o_psum_valid,
      output o_out_idx, o_busy, o_done, o_cfg_err
   );
endinterface

// File: rtl/pe_conv_ctrl_tap_cnt.sv
// Filter tap counter: synchronous clear, load, enable and terminal-count
// flag when the count equals i_last.
module pe_tap_cnt #(
   parameter int unsigned W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_ld,
   input  logic [W-1:0] i_ld_val,
   input  logic         i_en,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_ld) begin
         r_cnt <= i_ld_val;
      end else if (i_en) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == i_last);
endmodule

// File: rtl/pe_conv_ctrl.sv
// Row-convolution scheduler for one PE: walks filter taps per window,
// steps the ifmap window by the stride and hands finished psums to the writer.
module pe_conv_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int unsigned IF_ADDR_W = IF_ADDR_W_DEF,
   parameter int unsigned F_ADDR_W  = F_ADDR_W_DEF,
   parameter int unsigned OUT_W     = OUT_W_DEF
) (
   input logic           i_clk,
   input logic           i_rst,
   pe_conv_ctrl_if.slave bus
);
   localparam int unsigned FW = F_ADDR_W + 1;
   localparam int unsigned BW = IF_ADDR_W + 1;
   localparam logic [FW-1:0] F_MAX = FW'(1 << F_ADDR_W);

   state_t r_state, w_next;

   logic [FW-1:0]        r_f;
   logic [IF_ADDR_W-1:0] r_s;
   logic [IF_ADDR_W-1:0] r_last;
   logic [BW-1:0]        r_base;
   logic [OUT_W-1:0]     r_out_idx;
   logic                 r_err;

   logic [FW-1:0] w_k;
   logic          w_tc;
   logic          w_start;
   logic          w_cfg_bad;
   logic          w_fits;
   logic          w_accept;
   logic          w_k_clr;
   logic          w_k_en;

   assign w_start   = (r_state == ST_IDLE) && bus.i_start;
   assign w_cfg_bad = (r_f == '0) || (r_f > F_MAX) || (r_s == '0);
   assign w_fits    = fits(16'(r_base), 16'(r_f), 16'(r_last));
   assign w_accept  = (r_state == ST_WRITE) && bus.i_psum_ready;
   assign w_k_clr   = w_start || (r_state == ST_CLEAR);
   assign w_k_en    = (r_state == ST_MAC) && bus.i_if_ready && !w_tc;

   pe_tap_cnt #(.W(FW)) u_tap_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_k_clr),
      .i_ld    (1'b0),
      .i_ld_val('0),
      .i_en    (w_k_en),
      .i_last  (r_f - FW'(1)),
      .o_cnt   (w_k),
      .o_tc    (w_tc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // base is one bit wider than the ifmap address so base+S never wraps into a fit
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_f       <= '0;
         r_s       <= '0;
         r_last    <= '0;
         r_base    <= '0;
         r_out_idx <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_start) begin
            r_f       <= bus.i_filter_size;
            r_s       <= bus.i_stride;
            r_last    <= bus.i_ifmap_last;
            r_base    <= '0;
            r_out_idx <= '0;
         end
         if (w_accept) begin
            r_base    <= r_base + BW'(r_s);
            r_out_idx <= r_out_idx + OUT_W'(1);
         end
         if ((r_state == ST_CHECK) && w_cfg_bad) begin
            r_err <= 1'b1;
         end else if (r_state == ST_DONE) begin
            r_err <= 1'b0;
         end
      end
   end

   always_comb begin
      w_next           = r_state;
      bus.o_mac_en     = 1'b0;
      bus.o_acc_clr    = 1'b0;
      bus.o_psum_valid = 1'b0;
      bus.o_done       = 1'b0;
      bus.o_cfg_err    = 1'b0;
      bus.o_busy       = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE:  if (bus.i_start) w_next = ST_CHECK;
         ST_CHECK: begin
            if (w_cfg_bad || !w_fits) w_next = ST_DONE;
            else                      w_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            bus.o_acc_clr = 1'b1;
            w_next        = ST_MAC;
         end
         ST_MAC: begin
            bus.o_mac_en = bus.i_if_ready;
            if (bus.i_if_ready && w_tc) w_next = ST_WRITE;
         end
         ST_WRITE: begin
            bus.o_psum_valid = 1'b1;
            if (bus.i_psum_ready) w_next = ST_CHECK;
         end
         ST_DONE: begin
            bus.o_done    = 1'b1;
            bus.o_cfg_err = r_err;
            w_next        = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign bus.o_ifmap_addr  = IF_ADDR_W'(r_base + BW'(w_k));
   assign bus.o_filter_addr = w_k[F_ADDR_W-1:0];
   assign bus.o_out_idx     = r_out_idx;
endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Bench for pe_conv_ctrl: directed and random jobs checked against a
// window-list model built from the filter/stride/last rules.
module tb_pe_conv_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   pe_conv_ctrl_if #(.IF_ADDR_W(4), .F_ADDR_W(2), .OUT_W(4)) bus ();

   pe_conv_ctrl #(.IF_ADDR_W(4), .F_ADDR_W(2), .OUT_W(4)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {13'd0, bus.o_ifmap_addr, bus.o_filter_addr, bus.o_mac_en, bus.o_acc_clr,
              bus.o_psum_valid, bus.o_out_idx, bus.o_busy, bus.o_done, bus.o_cfg_err};
   endfunction

   // One job: builds the expected window bases, drives readies (forced holds
   // plus random stalls) and checks every cycle until done or abort.
   task automatic run_job(input int f, input int s, input int last,
                          input int p_if, input int p_ps,
                          input int if_hold, input int ps_hold, input int abort_win);
      int  bases[$];
      bit  err;
      int  nwin, win, macs, stall_if, stall_ps, clr_cnt, mac_cnt, ihold, phold;
      bit  in_win, finished, mac_phase, wr_phase, exp_mac;
      err = (f == 0) || (f > 4) || (s == 0);
      if (!err) for (int b = 0; b + f - 1 <= last; b += s) bases.push_back(b);
      nwin = bases.size();
      win = 0; macs = 0; stall_if = 0; stall_ps = 0; clr_cnt = 0; mac_cnt = 0;
      ihold = 0; phold = 0; in_win = 0; finished = 0;

      @(negedge clk);
      bus.i_start       = 1'b1;
      bus.i_filter_size = 3'(f);
      bus.i_stride      = 4'(s);
      bus.i_ifmap_last  = 4'(last);
      bus.i_if_ready    = 1'b1;
      bus.i_psum_ready  = 1'b1;
      #1;
      chk("idle_busy", bus.o_busy, 0);

      for (int cyc = 1; cyc <= 600; cyc++) begin
         @(negedge clk);
         // garbage config/start while busy must be ignored
         bus.i_start       = 1'($urandom_range(0, 1));
         bus.i_filter_size = 3'($urandom);
         bus.i_stride      = 4'($urandom);
         bus.i_ifmap_last  = 4'($urandom);
         mac_phase = in_win && (macs < f);
         wr_phase  = in_win && (macs == f);
         if (win == 0 && mac_phase && macs == 1 && ihold < if_hold) begin
            bus.i_if_ready = 1'b0;
            ihold++;
         end else begin
            bus.i_if_ready = ($urandom_range(0, 99) >= p_if);
         end
         if (win == 0 && wr_phase && phold < ps_hold) begin
            bus.i_psum_ready = 1'b0;
            phold++;
         end else begin
            bus.i_psum_ready = ($urandom_range(0, 99) >= p_ps);
         end
         #1;
         exp_mac = mac_phase && bus.i_if_ready;
         chk("busy", bus.o_busy, 1);
         chk("mac_en", bus.o_mac_en, exp_mac);
         chk("psum_valid", bus.o_psum_valid, wr_phase);
         if (cyc == 2) chk("first_acc_clr", bus.o_acc_clr, (nwin > 0));
         if (mac_phase && !bus.i_if_ready) stall_if++;
         if (wr_phase && !bus.i_psum_ready) stall_ps++;
         if (bus.o_mac_en && win < nwin) begin
            chk("ifmap_addr", bus.o_ifmap_addr, (bases[win] + macs) % 16);
            chk("filter_addr", bus.o_filter_addr, macs);
            macs++;
            mac_cnt++;
         end
         if (bus.o_acc_clr) begin
            chk("acc_clr_in_window", in_win, 0);
            clr_cnt++;
            in_win = 1;
            macs = 0;
         end
         if (wr_phase && bus.i_psum_ready) begin
            chk("out_idx", bus.o_out_idx, win % 16);
            win++;
            in_win = 0;
         end
         if (abort_win >= 0 && win == abort_win && in_win && macs == 1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            bus.i_start = 1'b0;
            #1;
            chk("post_rst_outputs", all_outs(), 0);
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               #1;
               chk("post_rst_done", bus.o_done, 0);
               chk("post_rst_busy", bus.o_busy, 0);
            end
            finished = 1;
            break;
         end
         if (bus.o_done) begin
            chk("done_cycle", cyc, 1 + nwin * (f + 3) + stall_if + stall_ps + 1);
            chk("cfg_err", bus.o_cfg_err, err);
            chk("windows", win, nwin);
            chk("acc_clr_count", clr_cnt, nwin);
            chk("mac_count", mac_cnt, nwin * f);
            @(negedge clk);
            bus.i_start = 1'b0;
            #1;
            chk("after_done_busy", bus.o_busy, 0);
            chk("after_done_pulse", bus.o_done, 0);
            finished = 1;
            break;
         end
      end
      bus.i_start = 1'b0;
      if (!finished) begin
         n_assert++;
         n_fail++;
         $error("FAIL timeout: observed no done, expected done within 600 cycles");
      end
   endtask

   initial begin
      bus.i_start       = 1'b0;
      bus.i_filter_size = '0;
      bus.i_stride      = '0;
      bus.i_ifmap_last  = '0;
      bus.i_if_ready    = 1'b0;
      bus.i_psum_ready  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b0;

      run_job(3, 1, 5, 0, 0, 0, 0, -1);
      run_job(2, 2, 4, 0, 0, 0, 0, -1);
      run_job(3, 1, 3, 0, 0, 2, 0, -1);
      run_job(3, 1, 5, 0, 0, 0, 5, -1);
      run_job(0, 1, 5, 0, 0, 0, 0, -1);
      run_job(3, 0, 5, 0, 0, 0, 0, -1);
      run_job(5, 1, 15, 0, 0, 0, 0, -1);
      run_job(3, 1, 1, 0, 0, 0, 0, -1);
      run_job(3, 1, 5, 0, 0, 0, 0, 1);
      run_job(2, 1, 3, 0, 0, 0, 0, -1);
      run_job(4, 15, 15, 0, 0, 0, 0, -1);
      run_job(1, 1, 15, 0, 0, 0, 0, -1);
      run_job(4, 3, 15, 30, 30, 0, 0, -1);

      for (int n = 0; n < 25; n++) begin
         run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 25, 25, 0, 0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
